// File: rtl/zeroriscy_instr_realigner_if.sv
// Handshake bundle between prefetch buffer, realigner and decoder/ID.
//  fetch_*  : word-aligned 32-bit fetch words from the prefetcher
//  instr_*  : one realigned instruction per handshake towards ID
//  branch_* : flush/redirect pulse and halfword target
//  comp_cnt_o : saturating count of issued compressed instructions
// slave = realigner view, master = environment view.
interface zeroriscy_instr_realigner_if #(
  parameter int AW  = 32,
  parameter int PCW = 16
);
  logic           fetch_valid_i;
  logic           fetch_ready_o;
  logic [31:0]    fetch_rdata_i;
  logic [AW-1:0]  fetch_addr_i;
  logic           instr_valid_o;
  logic           instr_ready_i;
  logic [31:0]    instr_rdata_o;
  logic [AW-1:0]  instr_addr_o;
  logic           instr_is_comp_o;
  logic           branch_i;
  logic [AW-1:0]  branch_addr_i;
  logic [PCW-1:0] comp_cnt_o;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
           branch_i, branch_addr_i,
    output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o,
           instr_is_comp_o, comp_cnt_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, fetch_addr_i, instr_ready_i,
           branch_i, branch_addr_i,
    input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o,
           instr_is_comp_o, comp_cnt_o
  );
endinterface

// File: rtl/zeroriscy_instr_realigner.sv
// Instruction realigner between the prefetch buffer and the compressed decoder.
// Turns word-aligned fetch words into one instruction per handshake: either a
// full 32-bit instruction or a zero-extended 16-bit one, tracking halfword
// alignment (including 32-bit instructions straddling two words) and branch
// targets at halfword addresses.
// Ports:
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of zeroriscy_instr_realigner_if (fetch, instr, branch,
//             compressed-instruction counter)
// Outputs are combinational from state/residue/fetch inputs (no added latency).
module zeroriscy_instr_realigner #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PERF_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  zeroriscy_instr_realigner_if.slave bus
);
  localparam int AW  = ADDR_WIDTH;
  localparam int PCW = PERF_CNT_WIDTH;

  typedef enum logic [1:0] {ALIGNED, UNALIGNED, BR_UNALIGNED} state_e;

  state_e          state_q, state_d;
  logic [15:0]     res_q, res_d;
  logic [AW-1:0]   res_addr_q, res_addr_d;
  logic [PCW-1:0]  cnt_q, cnt_d;

  logic [31:0]     f;
  logic [AW-1:0]   wa, wa_hi;
  logic            valid, fready, xfer, is_comp;
  logic [31:0]     rdata;
  logic [AW-1:0]   addr;

  // address LSBs are don't-care by definition
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.fetch_addr_i[1:0], bus.branch_addr_i[0]};

  function automatic logic is_c(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

  assign f     = bus.fetch_rdata_i;
  assign wa    = {bus.fetch_addr_i[AW-1:2], 2'b00};
  assign wa_hi = {bus.fetch_addr_i[AW-1:2], 2'b10};

  always_comb begin
    valid      = 1'b0;
    fready     = 1'b0;
    xfer       = 1'b0;
    rdata      = 32'h0;
    addr       = wa;
    state_d    = state_q;
    res_d      = res_q;
    res_addr_d = res_addr_q;

    unique case (state_q)
      ALIGNED: begin
        valid = bus.fetch_valid_i;
        xfer  = valid & bus.instr_ready_i;
        fready = xfer;
        if (!is_c(f[15:0])) begin
          rdata = f;
        end else begin
          rdata = {16'h0, f[15:0]};
          if (xfer) begin
            res_d      = f[31:16];
            res_addr_d = wa_hi;
            state_d    = UNALIGNED;
          end
        end
      end
      UNALIGNED: begin
        addr = res_addr_q;
        if (is_c(res_q)) begin
          // residue is a whole instruction; no fetch word needed
          valid = 1'b1;
          rdata = {16'h0, res_q};
          xfer  = bus.instr_ready_i;
          if (xfer) state_d = ALIGNED;
        end else begin
          // 32-bit instruction straddling residue and next word
          valid  = bus.fetch_valid_i;
          rdata  = {f[15:0], res_q};
          xfer   = valid & bus.instr_ready_i;
          fready = xfer;
          if (xfer) begin
            res_d      = f[31:16];
            res_addr_d = wa_hi;
          end
        end
      end
      BR_UNALIGNED: begin
        addr = wa_hi;
        if (is_c(f[31:16])) begin
          valid  = bus.fetch_valid_i;
          rdata  = {16'h0, f[31:16]};
          xfer   = valid & bus.instr_ready_i;
          fready = xfer;
          if (xfer) state_d = ALIGNED;
        end else begin
          // upper half starts a 32-bit instruction: swallow the word silently
          fready = bus.fetch_valid_i;
          if (bus.fetch_valid_i) begin
            res_d      = f[31:16];
            res_addr_d = wa_hi;
            state_d    = UNALIGNED;
          end
        end
      end
      default: state_d = ALIGNED;
    endcase

    // redirect overrides everything; the prefetcher flushes in the same cycle
    if (bus.branch_i) begin
      valid   = 1'b0;
      fready  = 1'b0;
      xfer    = 1'b0;
      res_d   = 16'h0;
      res_addr_d = res_addr_q;
      state_d = bus.branch_addr_i[1] ? BR_UNALIGNED : ALIGNED;
    end
  end

  assign is_comp = rdata[1:0] != 2'b11;

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && is_comp && (cnt_q != {PCW{1'b1}})) cnt_d = cnt_q + PCW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ALIGNED;
      res_q      <= 16'h0;
      res_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      res_addr_q <= res_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.instr_valid_o   = valid;
  assign bus.fetch_ready_o   = fready;
  assign bus.instr_rdata_o   = rdata;
  assign bus.instr_addr_o    = addr;
  assign bus.instr_is_comp_o = is_comp;
  assign bus.comp_cnt_o      = cnt_q;
endmodule

// File: tb/tb_zeroriscy_instr_realigner.sv
// Bench for zeroriscy_instr_realigner: directed scenarios plus a randomized
// instruction-stream test checked against a program-level model (instruction
// list with PCs, packed into fetch words).
module tb_zeroriscy_instr_realigner;
  localparam int AW  = 32;
  localparam int PCW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  zeroriscy_instr_realigner_if #(.AW(AW), .PCW(PCW)) bus ();

  zeroriscy_instr_realigner #(.ADDR_WIDTH(AW), .PERF_CNT_WIDTH(PCW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {valid, fetch_ready, is_comp, rdata, addr}
  function automatic logic [66:0] obs();
    return {bus.instr_valid_o, bus.fetch_ready_o, bus.instr_is_comp_o,
            bus.instr_rdata_o, bus.instr_addr_o};
  endfunction

  task automatic drive(input logic fv, input logic [31:0] fd, input logic [31:0] fa,
                       input logic rdy, input logic br, input logic [31:0] ba);
    @(negedge clk);
    bus.fetch_valid_i = fv;
    bus.fetch_rdata_i = fd;
    bus.fetch_addr_i  = fa;
    bus.instr_ready_i = rdy;
    bus.branch_i      = br;
    bus.branch_addr_i = ba;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.fetch_valid_i = 1'b0;
    bus.branch_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o} !== {2'b00, {PCW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state got %b exp 00_0", {bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o});
    end
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got %b exp 00", {bus.instr_valid_o, bus.fetch_ready_o});
    end
  endtask

  task automatic test_aligned();
    drive(1, 32'h0000_0013, 32'h100, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h100}) begin
      errors++; $display("FAIL aligned_w0 got %h exp %h", obs(), {3'b110, 32'h13, 32'h100});
    end
    drive(1, 32'h0040_0093, 32'h104, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0040_0093, 32'h104}) begin
      errors++; $display("FAIL aligned_w1 got %h exp %h", obs(), {3'b110, 32'h0040_0093, 32'h104});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o} !== {2'b00, 8'd0}) begin
      errors++; $display("FAIL aligned_cnt got %h exp 0", {bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o});
    end
  endtask

  task automatic test_compressed_pair();
    drive(1, 32'h4501_4501, 32'h200, 1, 0, 0);
    checks++;
    if (obs() !== {3'b111, 32'h0000_4501, 32'h200}) begin
      errors++; $display("FAIL comp_lo got %h exp %h", obs(), {3'b111, 32'h4501, 32'h200});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if (obs() !== {3'b101, 32'h0000_4501, 32'h202}) begin
      errors++; $display("FAIL comp_hi got %h exp %h", obs(), {3'b101, 32'h4501, 32'h202});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o} !== {2'b00, 8'd2}) begin
      errors++; $display("FAIL comp_cnt got %h exp 002", {bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o});
    end
  endtask

  task automatic test_straddle();
    drive(1, 32'h0013_4501, 32'h300, 1, 0, 0);
    checks++;
    if (obs() !== {3'b111, 32'h0000_4501, 32'h300}) begin
      errors++; $display("FAIL strad_c got %h exp %h", obs(), {3'b111, 32'h4501, 32'h300});
    end
    drive(1, 32'h1111_0000, 32'h304, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h302}) begin
      errors++; $display("FAIL strad_32 got %h exp %h", obs(), {3'b110, 32'h13, 32'h302});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if (obs() !== {3'b101, 32'h0000_1111, 32'h306}) begin
      errors++; $display("FAIL strad_res got %h exp %h", obs(), {3'b101, 32'h1111, 32'h306});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.comp_cnt_o} !== {1'b0, 8'd4}) begin
      errors++; $display("FAIL strad_cnt got %h exp 004", {bus.instr_valid_o, bus.comp_cnt_o});
    end
  endtask

  task automatic test_branch_unaligned();
    drive(0, 32'h0, 32'h0, 1, 1, 32'h402);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o} !== 2'b00) begin
      errors++; $display("FAIL br_cycle got %b exp 00", {bus.instr_valid_o, bus.fetch_ready_o});
    end
    drive(1, 32'h0013_4501, 32'h400, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o} !== 2'b01) begin
      errors++; $display("FAIL br_silent got %b exp 01", {bus.instr_valid_o, bus.fetch_ready_o});
    end
    drive(1, 32'h0001_0000, 32'h404, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h402}) begin
      errors++; $display("FAIL br_strad got %h exp %h", obs(), {3'b110, 32'h13, 32'h402});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if (obs() !== {3'b101, 32'h0000_0001, 32'h406}) begin
      errors++; $display("FAIL br_res got %h exp %h", obs(), {3'b101, 32'h1, 32'h406});
    end
    drive(0, 32'h0, 32'h0, 1, 1, 32'h402);
    drive(1, 32'h4501_0000, 32'h400, 1, 0, 0);
    checks++;
    if (obs() !== {3'b111, 32'h0000_4501, 32'h402}) begin
      errors++; $display("FAIL br_comp got %h exp %h", obs(), {3'b111, 32'h4501, 32'h402});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o} !== {2'b00, 8'd6}) begin
      errors++; $display("FAIL br_aligned got %h exp 006", {bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o});
    end
  endtask

  task automatic test_backpressure();
    drive(1, 32'h4501_4501, 32'h500, 1, 0, 0);
    checks++;
    if (obs() !== {3'b111, 32'h0000_4501, 32'h500}) begin
      errors++; $display("FAIL bp_first got %h exp %h", obs(), {3'b111, 32'h4501, 32'h500});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h1234_5678, 32'h504, 0, 0, 0);
      checks++;
      if (obs() !== {3'b101, 32'h0000_4501, 32'h502}) begin
        errors++; $display("FAIL bp_hold%0d got %h exp %h", i, obs(), {3'b101, 32'h4501, 32'h502});
      end
    end
    drive(0, 32'h0, 32'h0, 1, 1, 32'h600);
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o} !== 2'b00) begin
      errors++; $display("FAIL bp_branch got %b exp 00", {bus.instr_valid_o, bus.fetch_ready_o});
    end
    drive(1, 32'h0000_0013, 32'h600, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h600}) begin
      errors++; $display("FAIL bp_target got %h exp %h", obs(), {3'b110, 32'h13, 32'h600});
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if ({bus.instr_valid_o, bus.comp_cnt_o} !== {1'b0, 8'd7}) begin
      errors++; $display("FAIL bp_cnt got %h exp 007", {bus.instr_valid_o, bus.comp_cnt_o});
    end
  endtask

  task automatic test_saturation_and_async_reset();
    pulse_reset();
    // 127 words of two compressed instructions = 254 transfers
    for (int i = 0; i < 127; i++) begin
      drive(1, 32'h4501_4501, 32'h700, 1, 0, 0);
      drive(0, 32'h0, 32'h0, 1, 0, 0);
    end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    checks++;
    if (bus.comp_cnt_o !== 8'd254) begin
      errors++; $display("FAIL sat_pre got %0d exp 254", bus.comp_cnt_o);
    end
    // five more -> 259 = 2^PCW + 3 transfers in total
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h4501_4501, 32'h700, 1, 0, 0);
      drive(0, 32'h0, 32'h0, 1, 0, 0);
    end
    drive(1, 32'h4501_4501, 32'h700, 1, 0, 0);
    drive(0, 32'h0, 32'h0, 1, 1, 32'h800);
    checks++;
    if (bus.comp_cnt_o !== 8'hFF) begin
      errors++; $display("FAIL sat_cnt got %h exp ff", bus.comp_cnt_o);
    end
    // leave a non-compressed residue pending, then reset between edges
    drive(1, 32'h0013_4501, 32'h800, 1, 0, 0);
    drive(1, 32'h1111_0000, 32'h804, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h802}) begin
      errors++; $display("FAIL ar_pre got %h exp %h", obs(), {3'b110, 32'h13, 32'h802});
    end
    #1;
    rst = 1'b1;
    bus.fetch_valid_i = 1'b0;
    #1;
    checks++;
    if ({bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o} !== {2'b00, 8'd0}) begin
      errors++; $display("FAIL async_rst got %h exp 0", {bus.instr_valid_o, bus.fetch_ready_o, bus.comp_cnt_o});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h0000_0013, 32'h900, 1, 0, 0);
    checks++;
    if (obs() !== {3'b110, 32'h0000_0013, 32'h900}) begin
      errors++; $display("FAIL ar_post got %h exp %h", obs(), {3'b110, 32'h13, 32'h900});
    end
  endtask

  // Program-level model: a random instruction list laid out from a halfword
  // target, packed into words; the DUT must emit exactly that list with PCs.
  task automatic test_random_stream(input int trials);
    logic [31:0] tgt, wa, a, w, fd;
    logic [15:0] h;
    logic [15:0] hw[$];
    logic [31:0] qd[$];
    logic [31:0] qa[$];
    logic        pres, fv, rdy, ecomp;
    int          nw, widx, budget, n, mcnt;
    pulse_reset();
    mcnt = 0;
    for (int t = 0; t < trials; t++) begin
      tgt = $urandom & 32'hFFFF_FFFE;
      if (t == 1) tgt = 32'hFFFF_FFFA;
      if (t == 2) tgt = 32'h0000_1002;
      drive(0, 32'h0, 32'h0, 1'($urandom), 1, tgt);
      checks++;
      if ({bus.instr_valid_o, bus.fetch_ready_o} !== 2'b00) begin
        errors++; $display("FAIL rnd_branch%0d got %b exp 00", t, {bus.instr_valid_o, bus.fetch_ready_o});
      end
      hw.delete(); qd.delete(); qa.delete();
      wa = {tgt[31:2], 2'b00};
      a  = tgt;
      if (tgt[1]) hw.push_back(16'($urandom));
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          h = 16'($urandom);
          if (h[1:0] == 2'b11) h[0] = 1'b0;
          hw.push_back(h);
          qd.push_back({16'h0, h});
          qa.push_back(a);
          a = a + 32'd2;
        end else begin
          w = $urandom;
          w[1:0] = 2'b11;
          hw.push_back(w[15:0]);
          hw.push_back(w[31:16]);
          qd.push_back(w);
          qa.push_back(a);
          a = a + 32'd4;
        end
      end
      if (hw.size() % 2 != 0) hw.push_back(16'($urandom));
      nw = hw.size() / 2;
      widx = 0; pres = 1'b0; budget = 0;
      while (qd.size() > 0 && budget < 200) begin
        fv  = (widx < nw) && (pres || ($urandom_range(0, 3) != 0));
        rdy = ($urandom_range(0, 3) != 0);
        fd  = 32'h0;
        if (widx < nw) fd = {hw[2*widx+1], hw[2*widx]};
        drive(fv, fd, wa + 32'(4 * widx), rdy, 0, 0);
        checks++;
        if (bus.fetch_ready_o && !fv) begin
          errors++; $display("FAIL rnd_fready t%0d got 1 exp 0", t);
        end
        if (bus.instr_valid_o && rdy) begin
          ecomp = (qd[0][1:0] != 2'b11);
          checks++;
          if ({bus.instr_is_comp_o, bus.instr_rdata_o, bus.instr_addr_o} !== {ecomp, qd[0], qa[0]}) begin
            errors++;
            $display("FAIL rnd_instr t%0d got %b %h @%h exp %b %h @%h", t, bus.instr_is_comp_o,
                     bus.instr_rdata_o, bus.instr_addr_o, ecomp, qd[0], qa[0]);
          end
          if (ecomp && mcnt != 255) mcnt++;
          void'(qd.pop_front());
          void'(qa.pop_front());
        end
        if (fv && bus.fetch_ready_o) begin
          widx++;
          pres = 1'b0;
        end else begin
          pres = fv;
        end
        budget++;
      end
      if (qd.size() != 0) begin
        checks++; errors++;
        $display("FAIL rnd_timeout t%0d got %0d left exp 0", t, qd.size());
      end
    end
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    checks++;
    if (bus.comp_cnt_o !== PCW'(mcnt)) begin
      errors++; $display("FAIL rnd_cnt got %0d exp %0d", bus.comp_cnt_o, mcnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_rdata_i = 32'h0;
    bus.fetch_addr_i  = '0;
    bus.instr_ready_i = 1'b0;
    bus.branch_i      = 1'b0;
    bus.branch_addr_i = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_aligned();
    test_compressed_pair();
    test_straddle();
    test_branch_unaligned();
    test_backpressure();
    test_saturation_and_async_reset();
    test_random_stream(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
